// File: rtl/ack_axis_bridge.sv
// ---------------------------------------------------------------------------
// ack_axis_bridge
//
// Bridges an ACK-builder word stream to a NetFPGA AXI-Stream master.
// The upstream source has no back-pressure and leaves in_rdy high with stale
// data after its last word. An input FSM (ACCEPT / DROP / HOLD) therefore
// frames packets. Words are staged in a store-and-forward word FIFO. A small
// per-packet metadata FIFO (depth 4) tracks committed packets and, when
// enabled, their byte lengths.
//
// Optional feature macro: ACK_TUSER_LEN_EN
//   When defined, tuser[15:0] carries the packet byte length, computed as
//   (words-1)*bytes_per_word + popcount(last tkeep).
//   When undefined, tuser[15:0] is zero and no length logic is built.
//
// Ports
//   clk            : sole clock, rising edge
//   reset          : synchronous, active-high
//   in_rdy         : upstream word-valid level
//   in_tdata       : upstream word
//   in_tkeep       : upstream byte enables (not all-ones marks the last word)
//   m_axis_tdata   : output payload
//   m_axis_tkeep   : output byte enables
//   m_axis_tuser   : NetFPGA metadata ([31:24] dst port, [23:16] src port)
//   m_axis_tvalid  : output beat valid
//   m_axis_tlast   : final beat of a packet
//   m_axis_tready  : downstream back-pressure
//   pkt_drop_cnt   : saturating count of packets dropped for lack of room
// ---------------------------------------------------------------------------
module ack_axis_bridge #(
  parameter int         C_S_AXIS_DATA_WIDTH  = 256,
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter int         FIFO_DEPTH_BITS      = 3,
  parameter int         MAX_PKT_WORDS        = 4,
  parameter logic [7:0] DST_PORT             = 8'h01
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_rdy,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       in_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     in_tkeep,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [15:0]                          pkt_drop_cnt
);

  localparam int LP_KEEP_W    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int LP_DEPTH     = 1 << FIFO_DEPTH_BITS;
  localparam int LP_META_D    = 4;
  localparam int LP_WCNT_W    = $clog2(MAX_PKT_WORDS + 1);

  localparam logic [FIFO_DEPTH_BITS:0] LP_DEPTH_V  = (FIFO_DEPTH_BITS + 1)'(LP_DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0] LP_MAX_V    = (FIFO_DEPTH_BITS + 1)'(MAX_PKT_WORDS);
  localparam logic [LP_KEEP_W-1:0]     LP_KEEP_ALL = '1;
  localparam logic [LP_WCNT_W-1:0]     LP_LAST_IDX = LP_WCNT_W'(MAX_PKT_WORDS - 1);
  localparam logic [LP_WCNT_W-1:0]     LP_WCNT_ONE = LP_WCNT_W'(1);
  localparam logic [2:0]               LP_META_FULL = 3'(LP_META_D);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DROP   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Saturating 16-bit increment for the drop counter.
  function automatic logic [15:0] f_sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      return val;
    end
    return val + 16'd1;
  endfunction

`ifdef ACK_TUSER_LEN_EN
  function automatic logic [15:0] f_popcount(input logic [LP_KEEP_W-1:0] keep);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < LP_KEEP_W; i++) begin
      n = n + 16'(keep[i]);
    end
    return n;
  endfunction
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                          r_state;
  state_t                          w_state_nxt;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  r_data_mem [LP_DEPTH];
  logic [LP_KEEP_W-1:0]            r_keep_mem [LP_DEPTH];
  logic                            r_last_mem [LP_DEPTH];

  logic [FIFO_DEPTH_BITS-1:0]      r_wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0]      r_rd_ptr;
  logic [FIFO_DEPTH_BITS:0]        r_occ;
  logic [LP_WCNT_W-1:0]            r_wcnt;

  logic [1:0]                      r_meta_wr;
  logic [1:0]                      r_meta_rd;
  logic [2:0]                      r_meta_cnt;
  logic [15:0]                     r_drop_cnt;

`ifdef ACK_TUSER_LEN_EN
  logic [15:0]                     r_len_mem [LP_META_D];
  logic [15:0]                     w_len;
`endif

  logic [FIFO_DEPTH_BITS:0]        w_free;
  logic                            w_first;
  logic                            w_no_room;
  logic                            w_last_word;
  logic                            w_wr_en;
  logic                            w_commit;
  logic                            w_drop;
  logic                            w_rd;
  logic                            w_rd_last;

  // Room is judged from start-of-cycle occupancy so a concurrent read never
  // lets a packet in that could not be guaranteed MAX_PKT_WORDS slots.
  assign w_free      = LP_DEPTH_V - r_occ;
  assign w_first     = (r_wcnt == '0);
  assign w_no_room   = (w_free < LP_MAX_V) || (r_meta_cnt == LP_META_FULL);
  assign w_last_word = (in_tkeep != LP_KEEP_ALL) || (r_wcnt == LP_LAST_IDX);

`ifdef ACK_TUSER_LEN_EN
  assign w_len = 16'(r_wcnt) * 16'(LP_KEEP_W) + f_popcount(in_tkeep);
`endif

  // A packet becomes readable only once committed to the metadata FIFO, which
  // gives store-and-forward with one cycle of commit latency.
  assign m_axis_tvalid = (r_meta_cnt != 3'd0) && !reset;
  assign w_rd          = m_axis_tvalid && m_axis_tready;
  assign w_rd_last     = w_rd && r_last_mem[r_rd_ptr];

  // -------------------------------------------------------------------------
  // Input FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_ACCEPT: begin
        if (in_rdy) begin
          if (w_first && w_no_room) begin
            w_drop      = 1'b1;
            w_state_nxt = ST_DROP;
          end else begin
            w_wr_en = 1'b1;
            if (w_last_word) begin
              w_commit    = 1'b1;
              w_state_nxt = ST_HOLD;
            end
          end
        end
      end
      // Upstream keeps in_rdy high with stale data; only a low cycle re-arms.
      ST_DROP, ST_HOLD: begin
        if (!in_rdy) begin
          w_state_nxt = ST_ACCEPT;
        end
      end
      default: w_state_nxt = ST_ACCEPT;
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_wcnt     <= '0;
      r_meta_wr  <= '0;
      r_meta_rd  <= '0;
      r_meta_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_rd})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase

      if (w_commit) begin
        r_wcnt <= '0;
      end else if (w_wr_en) begin
        r_wcnt <= r_wcnt + LP_WCNT_ONE;
      end

      if (w_commit) begin
        r_meta_wr <= r_meta_wr + 1'b1;
      end
      if (w_rd_last) begin
        r_meta_rd <= r_meta_rd + 1'b1;
      end
      case ({w_commit, w_rd_last})
        2'b10:   r_meta_cnt <= r_meta_cnt + 1'b1;
        2'b01:   r_meta_cnt <= r_meta_cnt - 1'b1;
        default: r_meta_cnt <= r_meta_cnt;
      endcase

      if (w_drop) begin
        r_drop_cnt <= f_sat_inc16(r_drop_cnt);
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage (payload only; validity is tracked by the pointers above)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_data_mem[r_wr_ptr] <= in_tdata;
      r_keep_mem[r_wr_ptr] <= in_tkeep;
      r_last_mem[r_wr_ptr] <= w_last_word;
    end
  end

`ifdef ACK_TUSER_LEN_EN
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_len_mem[r_meta_wr] <= w_len;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Output: payload forced to zero whenever no beat is offered
  // -------------------------------------------------------------------------
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    m_axis_tuser = '0;
    if (m_axis_tvalid) begin
      m_axis_tdata        = r_data_mem[r_rd_ptr];
      m_axis_tkeep        = r_keep_mem[r_rd_ptr];
      m_axis_tlast        = r_last_mem[r_rd_ptr];
      m_axis_tuser[31:24] = DST_PORT;
`ifdef ACK_TUSER_LEN_EN
      m_axis_tuser[15:0]  = r_len_mem[r_meta_rd];
`endif
    end
  end

  assign pkt_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_ack_axis_bridge.sv
// ---------------------------------------------------------------------------
// tb_ack_axis_bridge
//
// Directed bench for ack_axis_bridge (default parameters). Output beats are
// recorded on the falling edge whenever tvalid & tready, and each scenario
// task compares them against the packets it expects.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ack_axis_bridge;

`ifdef ACK_TUSER_LEN_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         in_rdy;
  logic [255:0] in_tdata;
  logic [31:0]  in_tkeep;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [15:0]  pkt_drop_cnt;

  int total;
  int bad;

  logic [255:0] q_data[$];
  logic [31:0]  q_keep[$];
  logic         q_last[$];
  logic [127:0] q_user[$];

  logic [255:0] e_data[$];
  logic [31:0]  e_keep[$];
  logic         e_last[$];
  logic [127:0] e_user[$];

  ack_axis_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .in_rdy        (in_rdy),
    .in_tdata      (in_tdata),
    .in_tkeep      (in_tkeep),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_drop_cnt  (pkt_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready && !reset) begin
      q_data.push_back(m_axis_tdata);
      q_keep.push_back(m_axis_tkeep);
      q_last.push_back(m_axis_tlast);
      q_user.push_back(m_axis_tuser);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: time got %0t want below 100000", $time);
    $fatal(1, "simulation timeout");
  end

  function automatic logic [255:0] mkw(input int p, input int w);
    logic [31:0] t;
    t = 32'hA5000000 + 32'(p * 16 + w);
    return {8{t}};
  endfunction

  function automatic logic [127:0] mk_user(input logic [15:0] len);
    logic [127:0] u;
    u = '0;
    u[31:24] = 8'h01;
    u[15:0]  = LEN_EN ? len : 16'h0000;
    return u;
  endfunction

  function automatic void exp_push(input int p, input int words,
                                   input logic [31:0] lastkeep, input logic [15:0] len);
    for (int w = 0; w < words; w++) begin
      e_data.push_back(mkw(p, w));
      e_keep.push_back((w == words - 1) ? lastkeep : 32'hFFFFFFFF);
      e_last.push_back(w == words - 1);
      e_user.push_back(mk_user(len));
    end
  endfunction

  function automatic void clear_queues();
    q_data.delete(); q_keep.delete(); q_last.delete(); q_user.delete();
    e_data.delete(); e_keep.delete(); e_last.delete(); e_user.delete();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives 'words' words back to back, holds in_rdy high with stale data for
  // 'hold' cycles, then one in_rdy=0 cycle.
  task automatic send_pkt(input int p, input int words,
                          input logic [31:0] lastkeep, input int hold);
    for (int w = 0; w < words; w++) begin
      in_rdy   = 1'b1;
      in_tdata = mkw(p, w);
      in_tkeep = (w == words - 1) ? lastkeep : 32'hFFFFFFFF;
      tick();
    end
    repeat (hold) tick();
    in_rdy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_rdy = 1'b0; m_axis_tready = 1'b0;
    in_tdata = '0; in_tkeep = '0;
    tick(); tick();
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
    total++; if (m_axis_tdata !== 256'h0) begin bad++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
    total++; if (m_axis_tkeep !== 32'h0) begin bad++; $display("FAIL rst_tkeep: got %h want 0", m_axis_tkeep); end
    total++; if (m_axis_tuser !== 128'h0) begin bad++; $display("FAIL rst_tuser: got %h want 0", m_axis_tuser); end
    total++; if (pkt_drop_cnt !== 16'h0) begin bad++; $display("FAIL rst_drop: got %0d want 0", pkt_drop_cnt); end
    reset = 1'b0;
    tick();
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL post_rst_tvalid: got %b want 0", m_axis_tvalid); end
  endtask

  task automatic test_single();
    clear_queues();
    exp_push(0, 3, 32'hC0000000, 16'd66);
    m_axis_tready = 1'b1;
    in_rdy = 1'b1;
    in_tdata = mkw(0, 0); in_tkeep = 32'hFFFFFFFF; tick();
    in_tdata = mkw(0, 1); in_tkeep = 32'hFFFFFFFF; tick();
    in_tdata = mkw(0, 2); in_tkeep = 32'hC0000000;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_saf: tvalid got %b want 0", m_axis_tvalid); end
    tick();
    total++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b0, mkw(0, 0)}) begin
      bad++; $display("FAIL single_latency: valid/last got %b%b data %h want 10 %h",
                      m_axis_tvalid, m_axis_tlast, m_axis_tdata, mkw(0, 0));
    end
    repeat (3) tick();
    in_rdy = 1'b0;
    repeat (8) tick();
    total++;
    if (q_data.size() != e_data.size()) begin bad++; $display("FAIL single_beats: got %0d want %0d", q_data.size(), e_data.size()); end
    for (int i = 0; i < e_data.size() && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== e_data[i]) begin bad++; $display("FAIL single_data[%0d]: got %h want %h", i, q_data[i], e_data[i]); end
      total++;
      if ({q_keep[i], q_last[i], q_user[i]} !== {e_keep[i], e_last[i], e_user[i]}) begin
        bad++; $display("FAIL single_side[%0d]: got keep %h last %b user %h want keep %h last %b user %h",
                        i, q_keep[i], q_last[i], q_user[i], e_keep[i], e_last[i], e_user[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    exp_push(1, 3, 32'h0000FFFF, 16'd80);
    exp_push(2, 3, 32'hFFFF0000, 16'd80);
    m_axis_tready = 1'b0;
    send_pkt(1, 3, 32'h0000FFFF, 0);
    send_pkt(2, 3, 32'hFFFF0000, 0);
    for (int c = 0; c < 12; c++) begin
      total++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b0, mkw(1, 0)}) begin
        bad++; $display("FAIL b2b_stall[%0d]: valid/last %b%b data %h want 10 %h",
                        c, m_axis_tvalid, m_axis_tlast, m_axis_tdata, mkw(1, 0));
      end
      tick();
    end
    m_axis_tready = 1'b1;
    repeat (12) tick();
    total++;
    if (q_data.size() != e_data.size()) begin bad++; $display("FAIL b2b_beats: got %0d want %0d", q_data.size(), e_data.size()); end
    for (int i = 0; i < e_data.size() && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== e_data[i]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, q_data[i], e_data[i]); end
      total++;
      if ({q_keep[i], q_last[i], q_user[i]} !== {e_keep[i], e_last[i], e_user[i]}) begin
        bad++; $display("FAIL b2b_side[%0d]: got keep %h last %b user %h want keep %h last %b user %h",
                        i, q_keep[i], q_last[i], q_user[i], e_keep[i], e_last[i], e_user[i]);
      end
    end
  endtask

  task automatic test_drop();
    clear_queues();
    exp_push(10, 3, 32'h000000FF, 16'd72);
    exp_push(11, 3, 32'h000000FF, 16'd72);
    m_axis_tready = 1'b0;
    send_pkt(10, 3, 32'h000000FF, 2);
    send_pkt(11, 3, 32'h000000FF, 0);
    total++; if (pkt_drop_cnt !== 16'd0) begin bad++; $display("FAIL drop_before: got %0d want 0", pkt_drop_cnt); end
    send_pkt(12, 3, 32'h000000FF, 0);
    total++; if (pkt_drop_cnt !== 16'd1) begin bad++; $display("FAIL drop_cnt: got %0d want 1", pkt_drop_cnt); end
    m_axis_tready = 1'b1;
    repeat (12) tick();
    total++; if (pkt_drop_cnt !== 16'd1) begin bad++; $display("FAIL drop_cnt_after: got %0d want 1", pkt_drop_cnt); end
    total++;
    if (q_data.size() != e_data.size()) begin bad++; $display("FAIL drop_beats: got %0d want %0d", q_data.size(), e_data.size()); end
    for (int i = 0; i < e_data.size() && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== e_data[i]) begin bad++; $display("FAIL drop_data[%0d]: got %h want %h", i, q_data[i], e_data[i]); end
      total++;
      if ({q_keep[i], q_last[i], q_user[i]} !== {e_keep[i], e_last[i], e_user[i]}) begin
        bad++; $display("FAIL drop_side[%0d]: got keep %h last %b user %h want keep %h last %b user %h",
                        i, q_keep[i], q_last[i], q_user[i], e_keep[i], e_last[i], e_user[i]);
      end
    end
  endtask

  task automatic test_forced_last();
    clear_queues();
    exp_push(20, 4, 32'hFFFFFFFF, 16'd128);
    m_axis_tready = 1'b1;
    send_pkt(20, 5, 32'hFFFFFFFF, 0);
    repeat (10) tick();
    total++;
    if (q_data.size() != e_data.size()) begin bad++; $display("FAIL forced_beats: got %0d want %0d", q_data.size(), e_data.size()); end
    for (int i = 0; i < e_data.size() && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== e_data[i]) begin bad++; $display("FAIL forced_data[%0d]: got %h want %h", i, q_data[i], e_data[i]); end
      total++;
      if ({q_keep[i], q_last[i], q_user[i]} !== {e_keep[i], e_last[i], e_user[i]}) begin
        bad++; $display("FAIL forced_side[%0d]: got keep %h last %b user %h want keep %h last %b user %h",
                        i, q_keep[i], q_last[i], q_user[i], e_keep[i], e_last[i], e_user[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    m_axis_tready = 1'b0;
    send_pkt(30, 3, 32'h0000FFFF, 0);
    send_pkt(31, 3, 32'h0000FFFF, 0);
    m_axis_tready = 1'b1;
    tick();
    // beat 1 has transferred; beat 2 is on the bus when reset rises
    reset = 1'b1;
    #1;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_during: tvalid got %b want 0", m_axis_tvalid); end
    tick();
    reset = 1'b0;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_after: tvalid got %b want 0", m_axis_tvalid); end
    total++; if (pkt_drop_cnt !== 16'd0) begin bad++; $display("FAIL rmid_drop: got %0d want 0", pkt_drop_cnt); end
    total++;
    if (q_data.size() != 1 || q_data[0] !== mkw(30, 0)) begin
      bad++; $display("FAIL rmid_pre_beats: got %0d beats want 1 beat of %h", q_data.size(), mkw(30, 0));
    end
    clear_queues();
    exp_push(32, 3, 32'h0000000F, 16'd68);
    send_pkt(32, 3, 32'h0000000F, 0);
    repeat (10) tick();
    total++;
    if (q_data.size() != e_data.size()) begin bad++; $display("FAIL rmid_beats: got %0d want %0d", q_data.size(), e_data.size()); end
    for (int i = 0; i < e_data.size() && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== e_data[i]) begin bad++; $display("FAIL rmid_data[%0d]: got %h want %h", i, q_data[i], e_data[i]); end
      total++;
      if ({q_keep[i], q_last[i], q_user[i]} !== {e_keep[i], e_last[i], e_user[i]}) begin
        bad++; $display("FAIL rmid_side[%0d]: got keep %h last %b user %h want keep %h last %b user %h",
                        i, q_keep[i], q_last[i], q_user[i], e_keep[i], e_last[i], e_user[i]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    in_rdy = 1'b0;
    in_tdata = '0;
    in_tkeep = '0;
    m_axis_tready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_forced_last();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
